// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front-end for a byte-addressed, big-endian data memory with a
//   32-bit word port. Turns byte/halfword/word requests into aligned word
//   reads and writes, extends sub-word load results, and does read-modify-
//   write for sub-word stores. Misaligned or illegal requests complete in one
//   cycle with error=1 and never touch memory.
//
//   Ports
//     clock, reset                  clock, synchronous active-high reset
//     req_load, req_store           request strobes, sampled only in IDLE
//     size, load_unsigned           00 byte / 01 half / 10 word / 11 illegal
//     addr, store_data              byte address and store operand
//     busy, done, error             status; error valid with done
//     load_data                     extended load result, held until next load
//     mem_address, mem_write_data   aligned word address / write word
//     mem_read, mem_write           single-cycle memory strobes
//     mem_read_data                 memory output, valid the cycle after mem_read
//
//   state  | meaning
//   IDLE   | waiting for a request; decodes and latches it
//   RD     | mem_read strobe for the aligned word
//   EXT    | read data valid: extend into load_data or merge into write word
//   WR     | mem_write strobe for the aligned word
//   DONE   | one-cycle done pulse, error as decoded in IDLE

module mem_access_unit #(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_load,
   input  logic                  req_store,
   input  logic [1:0]            size,
   input  logic                  load_unsigned,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           store_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           load_data,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   output logic                  mem_read,
   output logic                  mem_write,
   input  logic [31:0]           mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_EXT,
      S_WR,
      S_DONE
   } state_t;

   state_t      state, state_nx;

   logic [1:0]  offs_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        load_q;
   logic        err_q;
   logic [31:0] sdata_q;

   logic        accept;
   logic        req_illegal;
   logic        req_misaligned;
   logic        req_err;
   logic        word_store;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept         = (state == S_IDLE) && (req_load || req_store);
   assign req_illegal    = (req_load && req_store) || (size == 2'b11);
   assign req_misaligned = ((size == 2'b01) && addr[0]) ||
                           ((size == 2'b10) && (addr[1:0] != 2'b00));
   assign req_err        = req_illegal || req_misaligned;
   assign word_store     = req_store && !req_load && (size == 2'b10);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (req_err)         state_nx = S_DONE;
               else if (word_store) state_nx = S_WR;
               else                 state_nx = S_RD;
            end
         end
         S_RD:    state_nx = S_EXT;
         S_EXT:   state_nx = load_q ? S_DONE : S_WR;
         S_WR:    state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign error     = (state == S_DONE) && err_q;
   assign mem_read  = (state == S_RD);
   assign mem_write = (state == S_WR);

   // Big-endian lane select: offset 0 is the most significant byte.
   always_comb begin
      byte_sel = 8'h00;
      case (offs_q)
         2'd0: byte_sel = mem_read_data[31:24];
         2'd1: byte_sel = mem_read_data[23:16];
         2'd2: byte_sel = mem_read_data[15:8];
         2'd3: byte_sel = mem_read_data[7:0];
         default: byte_sel = 8'h00;
      endcase
   end

   assign half_sel = offs_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];

   always_comb begin
      load_ext = mem_read_data;
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: load_ext = mem_read_data;
      endcase
   end

   always_comb begin
      merged = mem_read_data;
      if (size_q == 2'b00) begin
         case (offs_q)
            2'd0: merged[31:24] = sdata_q[7:0];
            2'd1: merged[23:16] = sdata_q[7:0];
            2'd2: merged[15:8]  = sdata_q[7:0];
            2'd3: merged[7:0]   = sdata_q[7:0];
            default: merged = mem_read_data;
         endcase
      end else if (offs_q[1]) begin
         merged[15:0] = sdata_q[15:0];
      end else begin
         merged[31:16] = sdata_q[15:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         offs_q         <= 2'b00;
         size_q         <= 2'b00;
         uns_q          <= 1'b0;
         load_q         <= 1'b0;
         err_q          <= 1'b0;
         sdata_q        <= 32'h0;
         load_data      <= 32'h0;
         mem_address    <= '0;
         mem_write_data <= 32'h0;
      end else begin
         state <= state_nx;
         if (accept) begin
            offs_q      <= addr[1:0];
            size_q      <= size;
            uns_q       <= load_unsigned;
            load_q      <= req_load;
            err_q       <= req_err;
            sdata_q     <= store_data;
            mem_address <= {addr[ADDR_WIDTH-1:2], 2'b00};
            // Word stores skip the read, so the write word is ready at once.
            if (!req_err && word_store)
               mem_write_data <= store_data;
         end
         if (state == S_EXT) begin
            if (load_q) load_data      <= load_ext;
            else        mem_write_data <= merged;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int AW = 11;

   logic          clock;
   logic          reset;
   logic          req_load;
   logic          req_store;
   logic [1:0]    size;
   logic          load_unsigned;
   logic [AW-1:0] addr;
   logic [31:0]   store_data;
   logic          busy;
   logic          done;
   logic          error;
   logic [31:0]   load_data;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_write_data;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_read_data;

   int tests_run;
   int tests_failed;

   logic [7:0] mem     [0:2047];
   logic [7:0] ref_mem [0:2047];

   int            obs_lat;
   int            obs_rd;
   int            obs_wr;
   logic          obs_err;
   logic          obs_overlap;
   logic          obs_idle_busy;
   logic [AW-1:0] obs_rd_addr;
   logic [AW-1:0] obs_wr_addr;
   logic [31:0]   obs_wr_data;
   logic [15:0]   obs_stat;

   mem_access_unit #(.ADDR_WIDTH(AW)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_load       (req_load),
      .req_store      (req_store),
      .size           (size),
      .load_unsigned  (load_unsigned),
      .addr           (addr),
      .store_data     (store_data),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .load_data      (load_data),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Big-endian byte memory with a registered read port.
   always @(posedge clock) begin
      if (mem_read === 1'b1)
         mem_read_data <= {mem[int'(mem_address)], mem[int'(mem_address) + 1],
                           mem[int'(mem_address) + 2], mem[int'(mem_address) + 3]};
      if (mem_write === 1'b1) begin
         mem[int'(mem_address)]     <= mem_write_data[31:24];
         mem[int'(mem_address) + 1] <= mem_write_data[23:16];
         mem[int'(mem_address) + 2] <= mem_write_data[15:8];
         mem[int'(mem_address) + 3] <= mem_write_data[7:0];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one request (called #1 after a posedge, DUT in IDLE), holds it
   // until done, then lets the DUT return to IDLE. Records what it saw.
   task automatic run_op(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [AW-1:0] a, input logic [31:0] sd);
      req_load = ld; req_store = st; size = sz; load_unsigned = uns;
      addr = a; store_data = sd;
      obs_lat = 0; obs_rd = 0; obs_wr = 0; obs_err = 1'b0;
      obs_overlap = 1'b0; obs_idle_busy = 1'b0;
      obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clock); #1;
         if (mem_read === 1'b1) begin obs_rd++; obs_rd_addr = mem_address; end
         if (mem_write === 1'b1) begin obs_wr++; obs_wr_addr = mem_address; obs_wr_data = mem_write_data; end
         if (mem_read === 1'b1 && mem_write === 1'b1) obs_overlap = 1'b1;
         if (busy !== 1'b1) obs_idle_busy = 1'b1;
         if (done === 1'b1) begin obs_lat = i; obs_err = error; break; end
      end
      req_load = 1'b0; req_store = 1'b0;
      obs_stat = {4'(obs_lat), 4'(obs_rd), 4'(obs_wr), 3'b000, obs_err};
      @(posedge clock); #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_load = 1'b1; size = 2'b10; addr = '0;
      repeat (2) @(posedge clock);
      #1;
      tests_run++;
      if ({busy, done, error, mem_read, mem_write} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 00000", {busy, done, error, mem_read, mem_write});
      end
      tests_run++;
      if ({load_data, mem_write_data, 21'(mem_address)} !== 85'h0) begin
         tests_failed++;
         $display("FAIL reset_regs: got %h/%h/%h expected 0/0/0", load_data, mem_write_data, mem_address);
      end
      req_load = 1'b0;
      reset = 1'b0;
      @(posedge clock); #1;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_directed;
      {mem[16], mem[17], mem[18], mem[19]} = 32'h8899AABB;
      {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]} = 32'h8899AABB;

      run_op(1, 0, 2'b00, 0, 11'h011, 32'h0);
      tests_run++; if (obs_stat !== 16'h3100) begin tests_failed++; $display("FAIL lb_status: got %h expected 3100", obs_stat); end
      tests_run++; if (load_data !== 32'hFFFFFF99) begin tests_failed++; $display("FAIL lb_data: got %h expected ffffff99", load_data); end

      run_op(1, 0, 2'b00, 1, 11'h011, 32'h0);
      tests_run++; if (load_data !== 32'h00000099) begin tests_failed++; $display("FAIL lbu_data: got %h expected 00000099", load_data); end

      run_op(1, 0, 2'b01, 0, 11'h012, 32'h0);
      tests_run++; if (load_data !== 32'hFFFFAABB) begin tests_failed++; $display("FAIL lh_data: got %h expected ffffaabb", load_data); end

      run_op(1, 0, 2'b10, 0, 11'h010, 32'h0);
      tests_run++; if (obs_stat !== 16'h3100) begin tests_failed++; $display("FAIL lw_status: got %h expected 3100", obs_stat); end
      tests_run++; if (obs_rd_addr !== 11'h010) begin tests_failed++; $display("FAIL lw_addr: got %h expected 010", obs_rd_addr); end
      tests_run++; if (load_data !== 32'h8899AABB) begin tests_failed++; $display("FAIL lw_data: got %h expected 8899aabb", load_data); end

      run_op(0, 1, 2'b00, 0, 11'h013, 32'h123456CC);
      ref_mem[19] = 8'hCC;
      tests_run++; if (obs_stat !== 16'h4110) begin tests_failed++; $display("FAIL sb_status: got %h expected 4110", obs_stat); end
      tests_run++; if (obs_wr_data !== 32'h8899AACC) begin tests_failed++; $display("FAIL sb_wdata: got %h expected 8899aacc", obs_wr_data); end
      tests_run++; if (load_data !== 32'h8899AABB) begin tests_failed++; $display("FAIL sb_keeps_ld: got %h expected 8899aabb", load_data); end

      run_op(1, 0, 2'b10, 0, 11'h010, 32'h0);
      tests_run++; if (load_data !== 32'h8899AACC) begin tests_failed++; $display("FAIL lw_after_sb: got %h expected 8899aacc", load_data); end

      run_op(0, 1, 2'b10, 0, 11'h7FC, 32'hDEADBEEF);
      {ref_mem[2044], ref_mem[2045], ref_mem[2046], ref_mem[2047]} = 32'hDEADBEEF;
      tests_run++; if (obs_stat !== 16'h2010) begin tests_failed++; $display("FAIL sw_status: got %h expected 2010", obs_stat); end
      tests_run++; if (obs_wr_addr !== 11'h7FC) begin tests_failed++; $display("FAIL sw_addr: got %h expected 7fc", obs_wr_addr); end

      run_op(1, 0, 2'b10, 0, 11'h7FC, 32'h0);
      tests_run++; if (load_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_top: got %h expected deadbeef", load_data); end

      run_op(0, 1, 2'b01, 0, 11'h011, 32'h1111);
      tests_run++; if (obs_stat !== 16'h1001) begin tests_failed++; $display("FAIL sh_mis_status: got %h expected 1001", obs_stat); end
      run_op(1, 0, 2'b10, 0, 11'h012, 32'h0);
      tests_run++; if (obs_stat !== 16'h1001) begin tests_failed++; $display("FAIL lw_mis_status: got %h expected 1001", obs_stat); end
      run_op(1, 0, 2'b11, 0, 11'h010, 32'h0);
      tests_run++; if (obs_stat !== 16'h1001) begin tests_failed++; $display("FAIL size11_status: got %h expected 1001", obs_stat); end
      run_op(1, 1, 2'b10, 0, 11'h010, 32'h0);
      tests_run++; if (obs_stat !== 16'h1001) begin tests_failed++; $display("FAIL both_status: got %h expected 1001", obs_stat); end
      tests_run++; if (load_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL err_keeps_ld: got %h expected deadbeef", load_data); end
   endtask

   task automatic test_reset_mid_op;
      int wr_seen;
      wr_seen = 0;
      req_store = 1'b1; req_load = 1'b0; size = 2'b01; load_unsigned = 1'b0;
      addr = 11'h010; store_data = 32'h00005555;
      @(posedge clock); #1;
      if (mem_write === 1'b1) wr_seen++;
      @(posedge clock); #1;
      if (mem_write === 1'b1) wr_seen++;
      reset = 1'b1;
      @(posedge clock); #1;
      tests_run++;
      if ({busy, mem_write, mem_read} !== 3'b000) begin
         tests_failed++;
         $display("FAIL rst_mid_flags: got %b expected 000", {busy, mem_write, mem_read});
      end
      @(posedge clock); #1;
      if (mem_write === 1'b1) wr_seen++;
      req_store = 1'b0;
      reset = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
         if (mem_write === 1'b1) wr_seen++;
      end
      tests_run++;
      if (wr_seen !== 0) begin tests_failed++; $display("FAIL rst_mid_write: got %0d writes expected 0", wr_seen); end
      tests_run++;
      if ({mem[16], mem[17], mem[18], mem[19]} !== 32'h8899AACC) begin
         tests_failed++;
         $display("FAIL rst_mid_mem: got %h expected 8899aacc", {mem[16], mem[17], mem[18], mem[19]});
      end
      tests_run++;
      if (load_data !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_ld: got %h expected 0", load_data); end

      run_op(1, 0, 2'b10, 0, 11'h010, 32'h0);
      tests_run++; if (obs_stat !== 16'h3100) begin tests_failed++; $display("FAIL rst_lw_status: got %h expected 3100", obs_stat); end
      tests_run++; if (load_data !== 32'h8899AACC) begin tests_failed++; $display("FAIL rst_lw_data: got %h expected 8899aacc", load_data); end
   endtask

   task automatic test_random;
      logic          ld, st, uns, e;
      logic [1:0]    sz;
      logic [AW-1:0] a;
      logic [31:0]   sd, exp_ld, exp_word;
      logic [15:0]   exp_stat;
      logic [7:0]    b;
      logic [15:0]   h;
      int            w, ai, bad_bytes;
      int            r;

      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_ld = 32'h0;

      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 19);
         ld = (r == 0) || (r < 10);
         st = (r == 0) || (r >= 10);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         ai = $urandom_range(0, 2047);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b10)      ai = ai & ~3;
            else if (sz == 2'b01) ai = ai & ~1;
         end
         a   = AW'(ai);
         uns = 1'($urandom_range(0, 1));
         sd  = $urandom;
         w   = ai & ~3;

         e = (ld && st) || (sz == 2'b11) || (sz == 2'b01 && ai % 2 != 0) ||
             (sz == 2'b10 && ai % 4 != 0);
         if (e)             exp_stat = 16'h1001;
         else if (ld)       exp_stat = 16'h3100;
         else if (sz == 2)  exp_stat = 16'h2010;
         else               exp_stat = 16'h4110;

         run_op(ld, st, sz, uns, a, sd);

         if (!e && ld) begin
            case (sz)
               2'b00: begin
                  b = ref_mem[ai];
                  exp_ld = uns ? {24'h0, b} : {{24{b[7]}}, b};
               end
               2'b01: begin
                  h = {ref_mem[ai], ref_mem[ai + 1]};
                  exp_ld = uns ? {16'h0, h} : {{16{h[15]}}, h};
               end
               default: exp_ld = {ref_mem[ai], ref_mem[ai + 1], ref_mem[ai + 2], ref_mem[ai + 3]};
            endcase
         end
         if (!e && st) begin
            case (sz)
               2'b00: ref_mem[ai] = sd[7:0];
               2'b01: {ref_mem[ai], ref_mem[ai + 1]} = sd[15:0];
               default: {ref_mem[ai], ref_mem[ai + 1], ref_mem[ai + 2], ref_mem[ai + 3]} = sd;
            endcase
         end
         exp_word = {ref_mem[w], ref_mem[w + 1], ref_mem[w + 2], ref_mem[w + 3]};

         tests_run++;
         if (obs_stat !== exp_stat) begin
            tests_failed++;
            $display("FAIL rnd_status[%0d]: ld=%b st=%b sz=%0d a=%h got %h expected %h", n, ld, st, sz, a, obs_stat, exp_stat);
         end
         tests_run++;
         if (load_data !== exp_ld) begin
            tests_failed++;
            $display("FAIL rnd_load_data[%0d]: a=%h sz=%0d uns=%b got %h expected %h", n, a, sz, uns, load_data, exp_ld);
         end
         tests_run++;
         if (obs_overlap !== 1'b0 || obs_idle_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rnd_strobes[%0d]: overlap=%b busy_low=%b expected 0/0", n, obs_overlap, obs_idle_busy);
         end
         if (obs_rd > 0) begin
            tests_run++;
            if (obs_rd_addr !== AW'(w)) begin
               tests_failed++;
               $display("FAIL rnd_rd_addr[%0d]: got %h expected %h", n, obs_rd_addr, AW'(w));
            end
         end
         if (!e && st) begin
            tests_run++;
            if (obs_wr_addr !== AW'(w) || obs_wr_data !== exp_word) begin
               tests_failed++;
               $display("FAIL rnd_write[%0d]: got %h@%h expected %h@%h", n, obs_wr_data, obs_wr_addr, exp_word, AW'(w));
            end
         end
      end

      bad_bytes = 0;
      for (int i = 0; i < 2048; i++)
         if (mem[i] !== ref_mem[i]) bad_bytes++;
      tests_run++;
      if (bad_bytes != 0) begin
         tests_failed++;
         $display("FAIL rnd_mem_image: got %0d differing bytes expected 0", bad_bytes);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset = 1'b1;
      req_load = 1'b0; req_store = 1'b0; size = 2'b00; load_unsigned = 1'b0;
      addr = '0; store_data = '0;
      mem_read_data = '0;
      for (int i = 0; i < 2048; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      @(posedge clock); #1;

      test_reset;
      test_directed;
      test_reset_mid_op;
      test_random;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
